// File: rtl/mem_rr_arbiter_if.sv
// Request/response bundle between three requesters, the round-robin arbiter and the memory port.
// master = arbiter side, slave = requesters plus memory.
interface mem_rr_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [2:0]                   req_valid;
    logic [2:0]                   req_instr;
    logic [2:0][ADDR_W-1:0]       req_addr;
    logic [2:0][DATA_W-1:0]       req_wdata;
    logic [2:0][DATA_W/8-1:0]     req_wstrb;
    logic [2:0][DATA_W-1:0]       req_rdata;
    logic [2:0]                   req_ready;
    logic [2:0]                   req_error;

    logic                         memory_valid;
    logic                         memory_instr;
    logic [ADDR_W-1:0]            memory_addr;
    logic [DATA_W-1:0]            memory_wdata;
    logic [DATA_W/8-1:0]          memory_wstrb;
    logic [DATA_W-1:0]            memory_rdata;
    logic                         memory_ready;

    modport master (
        input  req_valid, req_instr, req_addr, req_wdata, req_wstrb,
        output req_rdata, req_ready, req_error,
        output memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
        input  memory_rdata, memory_ready
    );

    modport slave (
        output req_valid, req_instr, req_addr, req_wdata, req_wstrb,
        input  req_rdata, req_ready, req_error,
        input  memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
        output memory_rdata, memory_ready
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Three-way round-robin arbiter for the single memory port; one transaction outstanding at a time.
// Optional watchdog abort enabled by defining ARB_TIMEOUT_EN.
module mem_rr_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    mem_rr_arbiter_if.master  bus
);
    localparam int SW = DATA_W / 8;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e            state_q, state_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        grant_q, grant_d;
    logic              instr_q, instr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [SW-1:0]     wstrb_q, wstrb_d;

    logic [2:0][1:0]   order;
    logic [1:0]        pick;
    logic              pick_vld;
    logic              expire;

    // Search order starts just after the last served port so it drops to lowest priority.
    always_comb begin
        case (last_q)
            2'd0:    order = {2'd0, 2'd2, 2'd1};
            2'd1:    order = {2'd1, 2'd0, 2'd2};
            default: order = {2'd2, 2'd1, 2'd0};
        endcase
        pick     = last_q;
        pick_vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!pick_vld && bus.req_valid[order[k]]) begin
                pick     = order[k];
                pick_vld = 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire = (state_q == BUSY) && !bus.memory_ready && (cnt_q == CNT_W'(TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q != BUSY)
            cnt_d = '0;
        else if (!bus.memory_ready)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick;
                    instr_d = bus.req_instr[pick];
                    addr_d  = bus.req_addr[pick];
                    wdata_d = bus.req_wdata[pick];
                    wstrb_d = bus.req_wstrb[pick];
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.memory_ready || expire) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 2'd2;
            grant_q <= 2'd0;
            instr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    // Completion and abort pulses are combinational so the requester sees them in the memory_ready cycle.
    always_comb begin
        bus.req_ready = '0;
        bus.req_error = '0;
        for (int i = 0; i < 3; i++) begin
            bus.req_rdata[i] = bus.memory_rdata;
            if (state_q == BUSY && grant_q == 2'(i)) begin
                bus.req_ready[i] = bus.memory_ready;
                bus.req_error[i] = expire;
            end
        end
    end

    assign bus.memory_valid = (state_q == BUSY);
    assign bus.memory_instr = instr_q;
    assign bus.memory_addr  = addr_q;
    assign bus.memory_wdata = wdata_q;
    assign bus.memory_wstrb = wstrb_q;
endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
Three-requester round-robin arbiter that shares the single external memory port among instruction fetch (port 0), data load/store (port 1) and a debug/DMA master (port 2). It replaces the fixed two-way split between the cpu top and the memory bus. It serialises requests, holds the memory-side request stable until memory_ready, and routes the response back to the granted requester. At most one transaction is outstanding at any time.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; strobe width is DATA_W/8
TIMEOUT, 255, watchdog limit in cycles while BUSY; used only with ARB_TIMEOUT_EN

Ports:
rst  in  1  asynchronous reset, active high
clk  in  1  clock, rising edge
reqN_valid  in  1  request from requester N (N=0,1,2); held high until reqN_ready
reqN_instr  in  1  instruction-fetch qualifier from requester N
reqN_addr  in  ADDR_W  address from requester N
reqN_wdata  in  DATA_W  write data from requester N
reqN_wstrb  in  DATA_W/8  byte strobes from requester N; 0 means read
reqN_rdata  out  DATA_W  read data to requester N
reqN_ready  out  1  one-cycle completion pulse to requester N
reqN_error  out  1  one-cycle timeout-abort pulse to requester N
memory_valid  out  1  memory-side request
memory_instr  out  1  latched instr qualifier
memory_addr  out  ADDR_W  latched address
memory_wdata  out  DATA_W  latched write data
memory_wstrb  out  DATA_W/8  latched strobes
memory_rdata  in  DATA_W  memory read data, valid with memory_ready
memory_ready  in  1  memory completion

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; last=2, so requester 0 has highest priority first; memory_valid=0; memory_instr/addr/wdata/wstrb=0; all reqN_ready=0; reqN_error=0; timeout counter=0.
- FSM has two states: IDLE and BUSY.
- IDLE:
  - If any reqN_valid is high, grant the first valid requester in the order last+1, last+2, last (mod 3).
  - Latch its instr/addr/wdata/wstrb into the memory_* registers, store grant, set memory_valid=1 and go to BUSY on the same edge.
  - If no requester is valid, stay in IDLE with memory_valid=0.
- BUSY:
  - memory_* outputs are stable.
  - reqN_valid inputs are ignored, including new requests and changes on the granted port.
  - When memory_ready=1: reqN_ready for the granted N = 1 combinationally in that cycle; reqN_rdata = memory_rdata. Then clear memory_valid, set last=grant and go to IDLE on the next edge.
- Non-granted ports: reqN_ready=0; reqN_rdata=memory_rdata (don't-care).
- Latency: valid sampled at edge k puts memory_valid high after edge k. Minimum request-to-ready is 1 cycle; back-to-back service needs one IDLE cycle between transactions (2-cycle throughput per transaction).
- A requester whose valid is still high in the cycle after its ready pulse is treated as a new request.
- memory_ready while IDLE: ignored, no reqN_ready.
- Simultaneous valid on all ports every cycle: service order is 0,1,2,0,1,2,… with no starvation. Worst-case wait is 2 transactions.
- Reset asserted while BUSY: transaction abandoned, memory_valid drops asynchronously, no ready/error pulse.
- wstrb is passed through unmodified; the arbiter does not interpret it.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without memory_ready.
  - If the counter reaches TIMEOUT with memory_ready still 0, the granted reqN_error pulses for 1 cycle (reqN_ready stays 0), memory_valid clears, last=grant and state goes to IDLE.
  - memory_ready in the same cycle as the limit wins: normal completion, no error.
- When undefined: no counter is built, reqN_error are tied 0, and BUSY waits indefinitely.

Test Plan:
1. Single read: only req0_valid, addr=0x100, wstrb=0; memory_ready 1 cycle after memory_valid with rdata=0xDEADBEEF -> memory_addr=0x100; req0_ready pulses once with req0_rdata=0xDEADBEEF; back to IDLE.
2. Contention: req0, req1, req2 all valid from reset and re-asserted continuously, memory_ready always 1 -> grant order 0,1,2,0,1,2; each reqN_ready exactly once per 6 cycles.
3. Write pass-through: req1 addr=0x2000, wdata=0x12345678, wstrb=0x3, memory_ready delayed 5 cycles -> memory_* stay stable for all 5 cycles; req1_ready pulses in cycle 5; req0/req2 ready stay 0.
4. Request during BUSY: req2 granted; req0 rises mid-transaction -> req0 served only after req2_ready, with one IDLE cycle between.
5. Reset mid-BUSY: assert rst while memory_valid=1 -> memory_valid=0 without waiting for clk; after release, req0 wins if req0 and req1 are both valid.
6. With ARB_TIMEOUT_EN, TIMEOUT=4, memory_ready held 0 -> granted reqN_error pulses after 4 BUSY cycles; memory_valid drops; the next requester in rotation is granted.
